// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch reservation station
package branch_pkg;

  localparam int BR_XLEN = 32;
  localparam int BR_TAGW = 4;

  // A zero tag means the operand value field already holds the operand.
  localparam logic [BR_TAGW-1:0] TAG_INVALID = '0;

  // Encodings 6 and 7 are reserved and never resolve taken.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5
  } br_op_e;

  typedef struct packed {
    logic                          valid;
    logic [BR_TAGW-1:0]            target;
    logic [1:0][BR_TAGW-1:0]       tag;
    logic [1:0][BR_XLEN-1:0]       val;
    logic [BR_XLEN-1:0]            pc;
    logic [BR_XLEN-1:0]            offset;
    br_op_e                        op;
  } br_rs_entry_t;

endpackage

// File: rtl/branch_station_if.sv
// rtl/branch_station_if.sv - dispatch, broadcast and result bundle of the branch station
interface branch_station_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32,
  parameter int TAGW  = 4,
  parameter int NCDB  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [TAGW-1:0]      in_target;
  logic [TAGW-1:0]      in_tag1;
  logic [TAGW-1:0]      in_tag2;
  logic [XLEN-1:0]      in_val1;
  logic [XLEN-1:0]      in_val2;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_offset;
  logic [2:0]           in_op;
  logic [NCDB-1:0]      cdb_valid;
  logic [NCDB*TAGW-1:0] cdb_tag;
  logic [NCDB*XLEN-1:0] cdb_val;
  logic                 res_valid;
  logic                 res_ready;
  logic [TAGW-1:0]      res_target;
  logic                 res_taken;
  logic [XLEN-1:0]      res_next_pc;
  logic [CW-1:0]        count;

  modport master (
    output flush, in_valid, in_target, in_tag1, in_tag2, in_val1, in_val2,
           in_pc, in_offset, in_op, cdb_valid, cdb_tag, cdb_val, res_ready,
    input  in_ready, res_valid, res_target, res_taken, res_next_pc, count
  );

  modport slave (
    input  flush, in_valid, in_target, in_tag1, in_tag2, in_val1, in_val2,
           in_pc, in_offset, in_op, cdb_valid, cdb_tag, cdb_val, res_ready,
    output in_ready, res_valid, res_target, res_taken, res_next_pc, count
  );
endinterface

// File: rtl/br_compare.sv
// rtl/br_compare.sv - combinational branch condition evaluator
module br_compare
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  br_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  // Decode the comparison; reserved encodings fall through to not-taken.
  always_comb begin
    taken = 1'b0;
    case (op)
      BR_BEQ:  taken = (a == b);
      BR_BNE:  taken = (a != b);
      BR_BLT:  taken = ($signed(a) <  $signed(b));
      BR_BGE:  taken = ($signed(a) >= $signed(b));
      BR_BLTU: taken = (a <  b);
      BR_BGEU: taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_station.sv
// rtl/branch_station.sv - branch reservation station and resolver (option: BRANCH_STATION_WAKE_BYPASS_EN)
module branch_station
  import branch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XLEN  = BR_XLEN,
  parameter int TAGW  = BR_TAGW,
  parameter int NCDB  = 2
) (
  input logic             clk,
  input logic             rst,
  branch_station_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  br_rs_entry_t    q     [DEPTH];
  br_rs_entry_t    q_nxt [DEPTH];
  // Woken queue plus one extra slot where this cycle's dispatch lands.
  br_rs_entry_t    ext   [DEPTH+1];
  br_rs_entry_t    new_e;
  br_rs_entry_t    sel_e;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   sel_idx;
  logic            sel_found;
  logic            sel_taken;
  logic            in_fire;
  logic            issue;
  logic            res_valid_q;
  logic [TAGW-1:0] res_target_q;
  logic            res_taken_q;
  logic [XLEN-1:0] res_next_q;

  // Capture any matching broadcast; ports are scanned downward so port 0 wins.
  function automatic br_rs_entry_t wake(input br_rs_entry_t e,
                                        input logic [NCDB-1:0] cv,
                                        input logic [NCDB*TAGW-1:0] ct,
                                        input logic [NCDB*XLEN-1:0] cx);
    br_rs_entry_t r;
    r = e;
    for (int k = 0; k < 2; k++) begin
      for (int p = NCDB - 1; p >= 0; p--) begin
        if (e.tag[k] != TAG_INVALID && cv[p] && ct[p*TAGW +: TAGW] == e.tag[k]) begin
          r.tag[k] = TAG_INVALID;
          r.val[k] = cx[p*XLEN +: XLEN];
        end
      end
    end
    return r;
  endfunction

  assign bus.in_ready    = (cnt < CW'(DEPTH));
  assign in_fire         = bus.in_valid && bus.in_ready;
  assign bus.count       = cnt;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_target  = res_target_q;
  assign bus.res_taken   = res_taken_q;
  assign bus.res_next_pc = res_next_q;

  // Build the woken queue and append the dispatched entry at slot count.
  always_comb begin
    new_e        = '0;
    new_e.valid  = 1'b1;
    new_e.target = bus.in_target;
    new_e.tag[0] = bus.in_tag1;
    new_e.tag[1] = bus.in_tag2;
    new_e.val[0] = bus.in_val1;
    new_e.val[1] = bus.in_val2;
    new_e.pc     = bus.in_pc;
    new_e.offset = bus.in_offset;
    new_e.op     = br_op_e'(bus.in_op);
    for (int i = 0; i < DEPTH; i++) ext[i] = wake(q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
    ext[DEPTH] = '0;
    if (in_fire) ext[cnt] = wake(new_e, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
  end

  // Pick the oldest ready entry; the bypass build looks at post-wakeup tags.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef BRANCH_STATION_WAKE_BYPASS_EN
    for (int i = DEPTH; i >= 0; i--) begin
      if (ext[i].valid && ext[i].tag[0] == TAG_INVALID && ext[i].tag[1] == TAG_INVALID) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].valid && q[i].tag[0] == TAG_INVALID && q[i].tag[1] == TAG_INVALID) begin
        sel_found = 1'b1;
        sel_idx   = CW'(i);
      end
    end
`endif
  end

  assign sel_e = ext[sel_idx];
  assign issue = sel_found && (!res_valid_q || bus.res_ready);

  br_compare #(.XLEN(XLEN)) u_cmp (
    .op    (sel_e.op),
    .a     (sel_e.val[0]),
    .b     (sel_e.val[1]),
    .taken (sel_taken)
  );

  // Remove the issued entry and close the gap so slot 0 stays the oldest.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      q_nxt[i] = (issue && CW'(i) >= sel_idx) ? ext[i+1] : ext[i];
    end
    cnt_nxt = cnt + CW'(in_fire) - CW'(issue);
  end

  // Queue state; flush empties it ahead of any insert or wakeup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      cnt <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      cnt <= cnt_nxt;
    end
  end

  // Result slot: load on issue, hold while stalled, empty after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q  <= 1'b0;
      res_target_q <= '0;
      res_taken_q  <= 1'b0;
      res_next_q   <= '0;
    end else if (bus.flush) begin
      res_valid_q  <= 1'b0;
    end else if (issue) begin
      res_valid_q  <= 1'b1;
      res_target_q <= sel_e.target;
      res_taken_q  <= sel_taken;
      res_next_q   <= sel_e.pc + (sel_taken ? sel_e.offset : XLEN'(4));
    end else if (bus.res_ready) begin
      res_valid_q  <= 1'b0;
    end
  end

endmodule
